// File: rtl/hazard_ctrl.sv
// Hazard, flush and forwarding controller for the 5-stage MIPS pipeline, driven by an EX/MEM/WB scoreboard.
// Define HAZARD_FORWARDING_EN to enable operand forwarding; without it every RAW dependency stalls until writeback.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_wen,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              ex_valid, ex_wen, ex_memread, ex_uses_rs, ex_uses_rt;
    logic [REG_AW-1:0] ex_wreg, ex_rs, ex_rt;
    logic              mem_valid, mem_wen, mem_memread;
    logic [REG_AW-1:0] mem_wreg;
    logic              wb_valid, wb_wen;
    logic [REG_AW-1:0] wb_wreg;

    logic       load_use;
    logic       dep_stall;
    logic       stall_req;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    // Register 0 is hardwired, so it never counts as a produced value.
    function automatic logic writes(input logic v, input logic wen,
                                    input logic [REG_AW-1:0] wreg,
                                    input logic [REG_AW-1:0] r);
        return v && wen && (wreg == r) && (r != '0);
    endfunction

    always_comb begin
        load_use  = 1'b0;
        dep_stall = 1'b0;
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;

        load_use = id_valid && ex_memread &&
                   ((id_uses_rs && writes(ex_valid, ex_wen, ex_wreg, id_rs)) ||
                    (id_uses_rt && writes(ex_valid, ex_wen, ex_wreg, id_rt)));

        dep_stall = id_valid &&
                    ((id_uses_rs && (writes(ex_valid, ex_wen, ex_wreg, id_rs) ||
                                     writes(mem_valid, mem_wen, mem_wreg, id_rs) ||
                                     writes(wb_valid, wb_wen, wb_wreg, id_rs))) ||
                     (id_uses_rt && (writes(ex_valid, ex_wen, ex_wreg, id_rt) ||
                                     writes(mem_valid, mem_wen, mem_wreg, id_rt) ||
                                     writes(wb_valid, wb_wen, wb_wreg, id_rt))));

        // MEM is the youngest producer, but a load there has no data yet.
        if (ex_valid && ex_uses_rs) begin
            if (writes(mem_valid, mem_wen, mem_wreg, ex_rs) && !mem_memread)
                fwd_a_sel = 2'b01;
            else if (writes(wb_valid, wb_wen, wb_wreg, ex_rs))
                fwd_a_sel = 2'b10;
        end
        if (ex_valid && ex_uses_rt) begin
            if (writes(mem_valid, mem_wen, mem_wreg, ex_rt) && !mem_memread)
                fwd_b_sel = 2'b01;
            else if (writes(wb_valid, wb_wen, wb_wreg, ex_rt))
                fwd_b_sel = 2'b10;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    assign stall_req = load_use;
    assign fwd_a     = fwd_a_sel;
    assign fwd_b     = fwd_b_sel;
    logic unused_nofwd;
    assign unused_nofwd = dep_stall;
`else
    assign stall_req = dep_stall;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
    logic unused_fwd;
    assign unused_fwd = ^{load_use, fwd_a_sel, fwd_b_sel};
`endif

    // A taken branch squashes the ID instruction, so it overrides any stall.
    assign ifid_flush  = ex_branch_taken && !rst;
    assign idex_bubble = (ex_branch_taken || stall_req) && !rst;
    assign pc_stall    = stall_req && !ex_branch_taken && !rst;
    assign ifid_stall  = pc_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_memread  <= 1'b0;
            ex_uses_rs  <= 1'b0;
            ex_uses_rt  <= 1'b0;
            ex_wreg     <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            mem_valid   <= 1'b0;
            mem_wen     <= 1'b0;
            mem_memread <= 1'b0;
            mem_wreg    <= '0;
            wb_valid    <= 1'b0;
            wb_wen      <= 1'b0;
            wb_wreg     <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_wen      <= mem_wen;
            wb_wreg     <= mem_wreg;
            mem_valid   <= ex_valid;
            mem_wen     <= ex_wen;
            mem_memread <= ex_memread;
            mem_wreg    <= ex_wreg;
            ex_valid    <= id_valid && !idex_bubble;
            ex_wen      <= id_wen;
            ex_memread  <= id_memread;
            ex_uses_rs  <= id_uses_rs;
            ex_uses_rt  <= id_uses_rt;
            ex_wreg     <= id_wreg;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl, checked against an instruction-level pipeline model.
// Follows HAZARD_FORWARDING_EN the same way the design does.
module tb_hazard_ctrl;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_uses_rs, id_uses_rt, id_wen, id_memread;
    logic [REG_AW-1:0] id_rs, id_rt, id_wreg;
    logic              ex_branch_taken;
    logic              pc_stall, ifid_stall, idex_bubble, ifid_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cycles;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_wreg(id_wreg), .id_wen(id_wen), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v; int wreg; bit wen; bit mr; int rs; int rt; bit urs; bit urt;
    } instr_t;

    instr_t pipe[3];   // index 0 = EX, 1 = MEM, 2 = WB
    int model_cnt;
    int n_checks = 0;
    int n_fail   = 0;
    logic       obs_pc_stall, obs_flush, obs_bubble;
    logic [1:0] obs_fwd_a, obs_fwd_b;
    logic [CNT_W-1:0] obs_cnt;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    function automatic bit produces(instr_t x, int r);
        return x.v && x.wen && x.wreg == r && r != 0;
    endfunction

    // An operand needs the stall when its newest producer cannot yet supply it.
    function automatic bit model_stall();
        bit hit = 0;
        if (!id_valid) return 0;
        if (FWD) begin
            if (pipe[0].mr && ((id_uses_rs && produces(pipe[0], int'(id_rs))) ||
                               (id_uses_rt && produces(pipe[0], int'(id_rt)))))
                hit = 1;
        end else begin
            for (int k = 0; k < 3; k++)
                if ((id_uses_rs && produces(pipe[k], int'(id_rs))) ||
                    (id_uses_rt && produces(pipe[k], int'(id_rt))))
                    hit = 1;
        end
        return hit;
    endfunction

    function automatic int model_fwd(bit uses, int r);
        if (!FWD || !pipe[0].v || !uses) return 0;
        if (produces(pipe[1], r) && !pipe[1].mr) return 1;
        if (produces(pipe[2], r)) return 2;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int wreg, input bit wen, input bit mr, input bit br);
        id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_wreg = REG_AW'(wreg);
        id_wen = wen; id_memread = mr; ex_branch_taken = br;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        model_cnt = 0;
    endtask

    // Observe one cycle at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit st, br, stall_exp;
        instr_t nxt;
        @(negedge clk);
        st = model_stall();
        br = ex_branch_taken;
        stall_exp = st && !br;
        obs_pc_stall = pc_stall; obs_flush = ifid_flush; obs_bubble = idex_bubble;
        obs_fwd_a = fwd_a; obs_fwd_b = fwd_b; obs_cnt = stall_cycles;
        check("pc_stall", pc_stall, stall_exp);
        check("ifid_stall", ifid_stall, stall_exp);
        check("idex_bubble", idex_bubble, st || br);
        check("ifid_flush", ifid_flush, br);
        check("fwd_a", fwd_a, model_fwd(pipe[0].urs, pipe[0].rs));
        check("fwd_b", fwd_b, model_fwd(pipe[0].urt, pipe[0].rt));
        check("stall_cycles", stall_cycles, model_cnt);
        nxt.v = id_valid && !(st || br);
        nxt.wreg = int'(id_wreg); nxt.wen = id_wen; nxt.mr = id_memread;
        nxt.rs = int'(id_rs); nxt.rt = int'(id_rt); nxt.urs = id_uses_rs; nxt.urt = id_uses_rt;
        @(posedge clk);
        if (stall_exp && model_cnt < CNT_MAX) model_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        #1;
    endtask

    // Present an instruction in ID and keep it there until it is accepted into EX.
    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input int wreg, input bit wen, input bit mr);
        int guard = 0;
        set_id(1, rs, rt, urs, urt, wreg, wen, mr, 0);
        cycle();
        while (obs_pc_stall && guard < 8) begin
            cycle();
            guard++;
        end
        if (guard == 8) check("issue_timeout", 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_stall"}, pc_stall, 0);
        check({tag, "_ifid_stall"}, ifid_stall, 0);
        check({tag, "_bubble"}, idex_bubble, 0);
        check({tag, "_flush"}, ifid_flush, 0);
        check({tag, "_fwd_a"}, fwd_a, 0);
        check({tag, "_fwd_b"}, fwd_b, 0);
        check({tag, "_cnt"}, stall_cycles, 0);
    endtask

    initial begin
        int cnt_before;
        rst = 1'b1;
        set_id(1, 5, 5, 1, 1, 5, 1, 1, 1);
        clear_model();
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Load-use: lw $5 then add $6,$5,$1
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
        cycle();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
        cycle();
        check("lu_stall", obs_pc_stall, 1);
        check("lu_bubble", obs_bubble, 1);
        for (int g = 0; g < 8 && obs_pc_stall; g++) cycle();
        check("lu_release", obs_pc_stall, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("lu_fwd_a", obs_fwd_a, FWD ? 2 : 0);

        // ALU back-to-back: add $3,$1,$2 ; sub $4,$3,$3
        issue(1, 2, 1, 1, 3, 1, 0);
        issue(3, 3, 1, 1, 4, 1, 0);
        cycle();
        check("b2b_fwd_a", obs_fwd_a, FWD ? 1 : 0);
        check("b2b_fwd_b", obs_fwd_b, FWD ? 1 : 0);

        // Double producer: add $3 ; or $3 ; and $7,$3,$0
        issue(1, 2, 1, 1, 3, 1, 0);
        issue(1, 2, 1, 1, 3, 1, 0);
        issue(3, 0, 1, 1, 7, 1, 0);
        cycle();
        check("dbl_fwd_a", obs_fwd_a, FWD ? 1 : 0);
        check("dbl_fwd_b", obs_fwd_b, 0);

        // Register zero: lw $0 ; add $2,$0,$0
        issue(1, 0, 1, 0, 0, 1, 1);
        set_id(1, 0, 0, 1, 1, 2, 1, 0, 0);
        cycle();
        check("r0_stall", obs_pc_stall, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("r0_fwd_a", obs_fwd_a, 0);
        check("r0_fwd_b", obs_fwd_b, 0);

        // Branch taken in the same cycle as a load-use dependency
        issue(1, 0, 1, 0, 5, 1, 1);
        cnt_before = model_cnt;
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 1);
        cycle();
        check("br_flush", obs_flush, 1);
        check("br_bubble", obs_bubble, 1);
        check("br_pc_stall", obs_pc_stall, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("br_cnt_kept", obs_cnt, cnt_before);

        // Self-dependent load held in ID keeps producing stalls until saturation
        set_id(1, 5, 0, 1, 0, 5, 1, 1, 0);
        repeat (40) cycle();
        check("sat_cnt", obs_cnt, CNT_MAX);

        // Random traffic over a small register set so dependencies are frequent
        repeat (300) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            cycle();
        end

        // Reset while a load sits in MEM
        rst = 1'b0;
        clear_model();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, 0, 1, 0, 5, 1, 1);
        cycle();
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        clear_model();
        @(posedge clk); #1;
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 0);
        rst = 1'b0;
        cycle();
        check("post_rst_stall", obs_pc_stall, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("post_rst_fwd_a", obs_fwd_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It keeps an internal scoreboard of the instructions in EX, MEM and WB. From that scoreboard it drives the PC/IF-ID stall, the ID/EX bubble, the IF/ID flush and the ALU operand forwarding selects. It also counts stall cycles for performance visibility.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register rs
id_rt  in  REG_AW  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_wreg  in  REG_AW  ID destination register (after RegDst mux)
id_wen  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
ex_branch_taken  in  1  branch in EX resolved taken (zero & pc_control)
pc_stall  out  1  hold the PC
ifid_stall  out  1  hold the IF/ID register
idex_bubble  out  1  load a NOP into ID/EX
ifid_flush  out  1  clear the IF/ID register
fwd_a  out  2  ALU A select: 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data
fwd_b  out  2  ALU B select, same encoding as fwd_a
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. While rst is high:
  - all scoreboard valid bits are 0;
  - stall_cycles = 0;
  - all outputs are 0.
- Scoreboard: three slots, EX, MEM and WB. Each slot holds valid, wreg, wen, memread. The EX slot also holds rs, rt, uses_rs, uses_rt.
- Scoreboard update on each posedge clk:
  - WB <= MEM;
  - MEM <= EX;
  - EX <= ID fields if id_valid and no bubble; otherwise EX.valid <= 0.
- A slot is a "writer of r" when valid, wen, wreg == r and r != 0. Register 0 never creates a hazard or a forward.
- Load-use hazard (combinational): id_valid, and the EX slot is a writer of id_rs (with id_uses_rs) or of id_rt (with id_uses_rt), and EX.memread = 1.
- On a load-use hazard, in the same cycle: pc_stall = 1, ifid_stall = 1, idex_bubble = 1. This costs exactly one cycle. The next cycle the load is in MEM and forwarding from WB covers it.
- Branch flush: ex_branch_taken = 1 gives ifid_flush = 1 and idex_bubble = 1 in the same cycle. pc_stall = 0 and ifid_stall = 0 so the target is fetched. The branch penalty is 2 cycles.
- Simultaneous branch and load-use: the flush wins and the stall is suppressed, because the stalled instruction is on the wrong path.
- Forwarding is combinational from the registered EX slot. For fwd_a, with EX.uses_rs and r = EX.rs:
  - 01 if the MEM slot is a writer of r and MEM.memread = 0;
  - else 10 if the WB slot is a writer of r;
  - else 00.
  - MEM has priority over WB (youngest producer wins).
  - fwd_b is the same using rt.
  - An invalid EX slot gives 00.
- stall_cycles increments on each posedge where pc_stall = 1. It saturates at all ones and does not wrap.
- Reset mid-operation discards all in-flight scoreboard state. The first cycle after release has no hazards and no forwards.

Optional Feature:
Macro: HAZARD_FORWARDING_EN
- Defined: forwarding behaves as described above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - The stall condition becomes "any valid ID source register is written by the EX, MEM or WB slot", regardless of memread. The WB slot is included because the register file writes on posedge and reads the old value in that cycle.
  - The stall persists until the producer leaves WB: up to 3 cycles per dependency.
  - The branch flush has the same priority over the stall as above.

Test Plan:
- Load-use:
  - Stimulus: lw $5 enters EX while ID holds add $6,$5,$1 (id_uses_rs = 1).
  - Response: for one cycle pc_stall = ifid_stall = idex_bubble = 1 and stall_cycles = 1.
  - Response, next cycle: no stall. Once the add is in EX, fwd_a = 10.
- ALU back-to-back:
  - Stimulus: add $3,$1,$2 followed by sub $4,$3,$3.
  - Response: with sub in EX, fwd_a = fwd_b = 01 and no stall.
- Double producer:
  - Stimulus: add $3 ; or $3 ; and $7,$3,$0.
  - Response: with and in EX, fwd_a = 01 (MEM beats WB) and fwd_b = 00.
- Register zero:
  - Stimulus: lw $0 followed by add $2,$0,$0.
  - Response: no stall, and fwd_a = fwd_b = 00.
- Branch flush vs stall:
  - Stimulus: ex_branch_taken = 1 in the same cycle as a load-use condition.
  - Response: ifid_flush = 1, idex_bubble = 1, pc_stall = 0, and stall_cycles unchanged.
- Reset mid-operation and saturation:
  - Stimulus: assert rst while the MEM slot is valid.
  - Response: all outputs drop to 0 asynchronously, and the scoreboard is empty after release.
  - Stimulus: with CNT_W = 4, hold a load-use stall for 20 cycles.
  - Response: stall_cycles stops at 15.
